// File: rtl/death_race_kbd_pkg.sv
// Shared scan-code constants, FSM encoding and key-mapping helpers for the DeathRace keyboard decoder.
package death_race_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    localparam int NUM_KEYS    = 5;
    localparam int KEY_BIT_UP    = 0;
    localparam int KEY_BIT_DOWN  = 1;
    localparam int KEY_BIT_LEFT  = 2;
    localparam int KEY_BIT_RIGHT = 3;
    localparam int KEY_BIT_SPACE = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } kbd_state_t;

    // One-hot held-key mask for a data byte; arrows only exist in the extended set, space only outside it.
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic [7:0] code, input logic ext);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        if (ext) begin
            case (code)
                SC_UP:    m[KEY_BIT_UP]    = 1'b1;
                SC_DOWN:  m[KEY_BIT_DOWN]  = 1'b1;
                SC_LEFT:  m[KEY_BIT_LEFT]  = 1'b1;
                SC_RIGHT: m[KEY_BIT_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end else if (code == SC_SPACE) begin
            m[KEY_BIT_SPACE] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_PAUSE) || (code == SC_BAT_OK) || (code == SC_ACK) ||
               (code == SC_RESEND) || (code == SC_ECHO);
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Saturating up-counter that bounds how long a pending E0/F0 prefix may wait for its next byte.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int CNT_W          = 18
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != TERM_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == TERM_CNT);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, held-key levels and make/break events for DeathRace.
// Optional build macro KEY_REPEAT_FILTER_EN suppresses events for typematic repeats and unheld breaks.
//
// state       | meaning
// ST_IDLE     | no prefix pending
// ST_GOT_E0   | extended prefix seen, waiting for data or F0
// ST_GOT_F0   | break prefix seen, waiting for data
// ST_GOT_E0F0 | extended break prefix seen, waiting for data
module ps2_key_decoder
    import death_race_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int CNT_W          = 18
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_code_valid,
    input  logic [7:0] i_code,
    input  logic       i_code_err,
    output logic       o_key_up,
    output logic       o_key_down,
    output logic       o_key_left,
    output logic       o_key_right,
    output logic       o_key_space,
    output logic       o_key_event,
    output logic       o_key_break,
    output logic       o_key_ext,
    output logic [7:0] o_key_code,
    output logic       o_err_pulse
);

    kbd_state_t          r_state;
    kbd_state_t          w_state_nxt;
    logic [NUM_KEYS-1:0] r_levels;
    logic [NUM_KEYS-1:0] w_levels_nxt;
    logic                r_key_event;
    logic                r_key_break;
    logic                r_key_ext;
    logic [7:0]          r_key_code;
    logic                r_err_pulse;

    logic                w_expired;
    logic                w_ext;
    logic                w_brk;
    logic [NUM_KEYS-1:0] w_mask;
    logic                w_evt;
    logic                w_err;

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_prefix_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (i_code_valid),
        .i_enable (r_state != ST_IDLE),
        .o_expired(w_expired)
    );

    assign w_ext  = (r_state == ST_GOT_E0) || (r_state == ST_GOT_E0F0);
    assign w_brk  = (r_state == ST_GOT_F0) || (r_state == ST_GOT_E0F0);
    assign w_mask = key_mask(i_code, w_ext);

`ifdef KEY_REPEAT_FILTER_EN
    logic w_held;
    assign w_held = |(r_levels & w_mask);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_levels_nxt = r_levels;
        w_evt        = 1'b0;
        w_err        = 1'b0;
        if (i_code_valid) begin
            if (i_code_err) begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end else if (i_code == SC_EXT) begin
                w_state_nxt = ST_GOT_E0;
            end else if (i_code == SC_BRK) begin
                case (r_state)
                    ST_IDLE:   w_state_nxt = ST_GOT_F0;
                    ST_GOT_E0: w_state_nxt = ST_GOT_E0F0;
                    default:   w_state_nxt = r_state;
                endcase
            end else if (is_ignored(i_code)) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_IDLE;
                w_evt       = 1'b1;
                w_levels_nxt = w_brk ? (r_levels & ~w_mask) : (r_levels | w_mask);
`ifdef KEY_REPEAT_FILTER_EN
                // Held make or unheld break on a mapped key carries no new information.
                if ((w_mask != '0) && (w_held != w_brk)) begin
                    w_evt = 1'b0;
                end
`endif
            end
        end else if ((r_state != ST_IDLE) && w_expired) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_levels    <= '0;
            r_key_event <= 1'b0;
            r_key_break <= 1'b0;
            r_key_ext   <= 1'b0;
            r_key_code  <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_levels    <= w_levels_nxt;
            r_key_event <= w_evt;
            r_err_pulse <= w_err;
            if (w_evt) begin
                r_key_break <= w_brk;
                r_key_ext   <= w_ext;
                r_key_code  <= i_code;
            end
        end
    end

    assign o_key_up    = r_levels[KEY_BIT_UP];
    assign o_key_down  = r_levels[KEY_BIT_DOWN];
    assign o_key_left  = r_levels[KEY_BIT_LEFT];
    assign o_key_right = r_levels[KEY_BIT_RIGHT];
    assign o_key_space = r_levels[KEY_BIT_SPACE];
    assign o_key_event = r_key_event;
    assign o_key_break = r_key_break;
    assign o_key_ext   = r_key_ext;
    assign o_key_code  = r_key_code;
    assign o_err_pulse = r_err_pulse;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random byte streams against a prefix-flag model.
module tb_ps2_key_decoder;

    localparam int TIMEOUT = 100;

    logic       clk;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] code;
    logic       code_err;
    logic       key_up, key_down, key_left, key_right, key_space;
    logic       key_event, key_break, key_ext, err_pulse;
    logic [7:0] key_code;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending prefix flags, held keys, last event, idle gap since last byte.
    logic       m_ext, m_brk;
    logic [4:0] m_lvl;
    logic       m_evt, m_break, m_extq, m_err;
    logic [7:0] m_code;
    int         gap;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(18)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_code_valid(code_valid), .i_code(code), .i_code_err(code_err),
        .o_key_up(key_up), .o_key_down(key_down), .o_key_left(key_left), .o_key_right(key_right),
        .o_key_space(key_space), .o_key_event(key_event), .o_key_break(key_break), .o_key_ext(key_ext),
        .o_key_code(key_code), .o_err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] exp_mask(input logic [7:0] b, input logic ext);
        if (ext) begin
            if (b == 8'h75) return 5'b00001;
            if (b == 8'h72) return 5'b00010;
            if (b == 8'h6B) return 5'b00100;
            if (b == 8'h74) return 5'b01000;
            return 5'b00000;
        end
        return (b == 8'h29) ? 5'b10000 : 5'b00000;
    endfunction

    function automatic logic [4:0] levels();
        return {key_space, key_right, key_left, key_down, key_up};
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_lvl = '0; m_evt = 0; m_break = 0; m_extq = 0; m_err = 0; m_code = '0;
        gap = 1000;
    endtask

    task automatic model_step(input logic [7:0] b, input logic e);
        logic [4:0] mk;
        logic       held, fire;
        if ((m_ext || m_brk) && gap > TIMEOUT) begin
            m_ext = 0; m_brk = 0;
        end
        m_evt = 0; m_err = 0;
        if (e) begin
            m_err = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1 || b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE) begin
            m_ext = 0; m_brk = 0;
        end else begin
            mk   = exp_mask(b, m_ext);
            held = (m_lvl & mk) != 0;
            fire = 1;
`ifdef KEY_REPEAT_FILTER_EN
            if (mk != 0 && !m_brk && held) fire = 0;
            if (mk != 0 && m_brk && !held) fire = 0;
`endif
            if (m_brk) m_lvl = m_lvl & ~mk;
            else       m_lvl = m_lvl | mk;
            if (fire) begin
                m_evt = 1; m_break = m_brk; m_extq = m_ext; m_code = b;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Presents one byte for one cycle; returns #1 after the edge that captured it.
    task automatic send(input logic [7:0] b, input logic e);
        model_step(b, e);
        code = b; code_err = e; code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0; code_err = 1'b0;
        gap = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            gap++;
            n_checks++;
            if (key_event !== 1'b0 || err_pulse !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_strobe: event=%b err=%b required 0 0", key_event, err_pulse);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({levels(), key_event, key_break, key_ext, err_pulse, key_code} !== 17'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {levels(), key_event, key_break, key_ext, err_pulse, key_code});
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_make_break();
        send(8'hE0, 0); send(8'h75, 0);
        n_checks++;
        if ({key_up, key_event, key_ext, key_break, key_code} !== {4'b1110, 8'h75}) begin
            n_errors++;
            $display("FAIL up_make: got up/evt/ext/brk/code=%b%b%b%b %h required 1110 75",
                     key_up, key_event, key_ext, key_break, key_code);
        end
        idle(1);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
        n_checks++;
        if ({key_up, key_event, key_ext, key_break, key_code} !== {4'b0111, 8'h75}) begin
            n_errors++;
            $display("FAIL up_break: got up/evt/ext/brk/code=%b%b%b%b %h required 0111 75",
                     key_up, key_event, key_ext, key_break, key_code);
        end
        idle(2);
    endtask

    task automatic test_non_ext();
        send(8'h75, 0);
        n_checks++;
        if ({key_up, key_event, key_ext} !== 3'b010) begin
            n_errors++;
            $display("FAIL plain_75: got up/evt/ext=%b%b%b required 010", key_up, key_event, key_ext);
        end
        send(8'h29, 0);
        n_checks++;
        if ({key_space, key_event, key_break, key_code} !== {3'b110, 8'h29}) begin
            n_errors++;
            $display("FAIL space_make: got space/evt/brk=%b%b%b %h required 110 29",
                     key_space, key_event, key_break, key_code);
        end
        send(8'hF0, 0); send(8'h29, 0);
        n_checks++;
        if ({key_space, key_event, key_break} !== 3'b011) begin
            n_errors++;
            $display("FAIL space_break: got space/evt/brk=%b%b%b required 011", key_space, key_event, key_break);
        end
        idle(2);
    endtask

    task automatic test_timeout();
        send(8'hE0, 0); idle(TIMEOUT + 1); send(8'h74, 0);
        n_checks++;
        if ({key_right, key_event, key_ext, key_code} !== {3'b010, 8'h74}) begin
            n_errors++;
            $display("FAIL timeout_expired: got right/evt/ext=%b%b%b %h required 010 74",
                     key_right, key_event, key_ext, key_code);
        end
        send(8'hE0, 0); idle(TIMEOUT); send(8'h74, 0);
        n_checks++;
        if ({key_right, key_event, key_ext} !== 3'b111) begin
            n_errors++;
            $display("FAIL timeout_valid_wins: got right/evt/ext=%b%b%b required 111", key_right, key_event, key_ext);
        end
        send(8'hE0, 0); send(8'hF0, 0); send(8'h74, 0);
        n_checks++;
        if (key_right !== 1'b0) begin
            n_errors++;
            $display("FAIL right_release: got %b required 0", key_right);
        end
        idle(2);
    endtask

    task automatic test_error();
        send(8'hE0, 1);
        n_checks++;
        if ({err_pulse, key_event} !== 2'b10) begin
            n_errors++;
            $display("FAIL err_pulse: got err/evt=%b%b required 10", err_pulse, key_event);
        end
        idle(1);
        send(8'h6B, 0);
        n_checks++;
        if ({key_left, key_event, key_ext} !== 3'b010) begin
            n_errors++;
            $display("FAIL err_prefix_lost: got left/evt/ext=%b%b%b required 010", key_left, key_event, key_ext);
        end
        send(8'hE0, 0); send(8'h6B, 0); send(8'hE0, 0); send(8'h72, 0);
        n_checks++;
        if (levels() !== 5'b00110) begin
            n_errors++;
            $display("FAIL two_keys_held: got %b required 00110", levels());
        end
        send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h72, 0);
        idle(2);
    endtask

    task automatic test_repeat();
        int evts, exp_evts;
        evts = 0;
        for (int r = 0; r < 3; r++) begin
            send(8'hE0, 0); send(8'h75, 0);
            if (key_event) evts++;
        end
`ifdef KEY_REPEAT_FILTER_EN
        exp_evts = 1;
`else
        exp_evts = 3;
`endif
        n_checks++;
        if (evts !== exp_evts || key_up !== 1'b1) begin
            n_errors++;
            $display("FAIL repeat_make: got events=%0d up=%b required %0d 1", evts, key_up, exp_evts);
        end
        evts = 0;
        for (int r = 0; r < 2; r++) begin
            send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
            if (key_event) evts++;
        end
`ifdef KEY_REPEAT_FILTER_EN
        exp_evts = 1;
`else
        exp_evts = 2;
`endif
        n_checks++;
        if (evts !== exp_evts || key_up !== 1'b0) begin
            n_errors++;
            $display("FAIL repeat_break: got events=%0d up=%b required %0d 0", evts, key_up, exp_evts);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({levels(), key_event, key_break, key_ext, err_pulse, key_code} !== 17'h0) begin
            n_errors++;
            $display("FAIL reset_mid: got %h required 0",
                     {levels(), key_event, key_break, key_ext, err_pulse, key_code});
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h75, 0);
        n_checks++;
        if ({key_up, key_event, key_ext} !== 3'b010) begin
            n_errors++;
            $display("FAIL reset_prefix_lost: got up/evt/ext=%b%b%b required 010", key_up, key_event, key_ext);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [7:0] pool [12];
        logic [7:0] b;
        logic       e;
        int         sel;
        pool = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'hE1, 8'hAA, 8'h1C};
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 10)      idle($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
            else if (sel < 60) idle($urandom_range(0, 3));
            b = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
            e = ($urandom_range(0, 19) == 0);
            send(b, e);
            n_checks++;
            if (levels() !== m_lvl) begin
                n_errors++;
                $display("FAIL rnd_levels #%0d byte %h: got %b required %b", i, b, levels(), m_lvl);
            end
            n_checks++;
            if ({key_event, err_pulse, key_break, key_ext, key_code} !== {m_evt, m_err, m_break, m_extq, m_code}) begin
                n_errors++;
                $display("FAIL rnd_event #%0d byte %h: got evt/err/brk/ext=%b%b%b%b %h required %b%b%b%b %h",
                         i, b, key_event, err_pulse, key_break, key_ext, key_code,
                         m_evt, m_err, m_break, m_extq, m_code);
            end
        end
        idle(2);
    endtask

    initial begin
        code_valid = 1'b0;
        code       = 8'h00;
        code_err   = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_make_break();
        test_non_ext();
        test_timeout();
        test_error();
        test_repeat();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
